// File: rtl/btn_debounce_if.sv
// Signal bundle between a raw pushbutton pin and the debounced control outputs.
// master drives the pin and observes the outputs; slave is the debouncer side.
interface btn_debounce_if;
  logic btn_in;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_long;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long
  );
endinterface

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: synchroniser, debounce FSM, registered level and press/release strobes.
// Defining BTN_LONG_PRESS_EN adds a one-shot long-press strobe; otherwise btn_long is tied low.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter bit          BTN_ACTIVE_HIGH   = 1'b1,
  parameter int unsigned LONG_PRESS_CYCLES = 200000000
) (
  input logic           sysclk,
  input logic           reset_n,
  btn_debounce_if.slave bus
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] DebMax = CntW'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("btn_debounce: DEBOUNCE_CYCLES must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("btn_debounce: SYNC_STAGES must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StPressWait, StPressed, StReleaseWait} state_e;

  logic                   btn_norm;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  state_e                 state_q;
  logic [CntW-1:0]        deb_cnt_q;
  logic                   level_q;
  logic                   press_q;
  logic                   release_q;
  logic                   press_accept;

  // Normalise polarity before the synchroniser so reset value 0 always means not pressed.
  assign btn_norm = BTN_ACTIVE_HIGH ? bus.btn_in : ~bus.btn_in;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_norm};
    end
  end

  assign sync         = sync_q[SYNC_STAGES-1];
  assign press_accept = (state_q == StPressWait) && sync && (deb_cnt_q == DebMax);

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (sync) begin
            state_q   <= StPressWait;
            deb_cnt_q <= CntW'(1);
          end
        end
        StPressWait: begin
          if (!sync) begin
            state_q   <= StIdle;
            deb_cnt_q <= '0;
          end else if (deb_cnt_q == DebMax) begin
            state_q   <= StPressed;
            deb_cnt_q <= '0;
            level_q   <= 1'b1;
            press_q   <= 1'b1;
          end else begin
            deb_cnt_q <= deb_cnt_q + CntW'(1);
          end
        end
        StPressed: begin
          if (!sync) begin
            state_q   <= StReleaseWait;
            deb_cnt_q <= CntW'(1);
          end
        end
        StReleaseWait: begin
          if (sync) begin
            state_q   <= StPressed;
            deb_cnt_q <= '0;
          end else if (deb_cnt_q == DebMax) begin
            state_q   <= StIdle;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            deb_cnt_q <= deb_cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q   <= StIdle;
          deb_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned HoldW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_PRESS_CYCLES);

  if (LONG_PRESS_CYCLES < 1) begin : g_bad_long
    $error("btn_debounce: LONG_PRESS_CYCLES must be at least 1");
  end

  logic [HoldW-1:0] hold_cnt_q;
  logic             long_q;

  // Only a fresh press clears the hold count, so a release bounce cannot re-arm btn_long.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (press_accept) begin
        hold_cnt_q <= '0;
      end else if ((state_q == StPressed || state_q == StReleaseWait) && hold_cnt_q != HoldMax) begin
        hold_cnt_q <= hold_cnt_q + HoldW'(1);
        long_q     <= (hold_cnt_q == HoldMax - HoldW'(1));
      end
    end
  end

  assign bus.btn_long = long_q;
`else
  assign bus.btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: expected strobes are queued with their step index
// and popped as the DUT raises them; btn_level is checked every step.
module tb_btn_debounce;

  localparam int KPress   = 0;
  localparam int KRelease = 1;
  localparam int KLong    = 2;

  typedef struct {
    int kind;
    int step;
  } ev_t;

  logic sysclk;
  logic reset_n;
  int   n_cmp;
  int   n_err;
  ev_t  exp_q[$];
  ev_t  ev;
  logic [2:0] obs;
  logic lvl;

  btn_debounce_if bus_h ();
  btn_debounce_if bus_l ();

  btn_debounce #(
    .DEBOUNCE_CYCLES  (4),
    .SYNC_STAGES      (2),
    .BTN_ACTIVE_HIGH  (1'b1),
    .LONG_PRESS_CYCLES(10)
  ) dut_h (
    .sysclk (sysclk),
    .reset_n(reset_n),
    .bus    (bus_h)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES  (4),
    .SYNC_STAGES      (2),
    .BTN_ACTIVE_HIGH  (1'b0),
    .LONG_PRESS_CYCLES(10)
  ) dut_l (
    .sysclk (sysclk),
    .reset_n(reset_n),
    .bus    (bus_l)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  function automatic string kname(int k);
    case (k)
      KPress:   return "press";
      KRelease: return "release";
      default:  return "long";
    endcase
  endfunction

  task automatic push(input int kind, input int step);
    ev_t e;
    e.kind = kind;
    e.step = step;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    bus_h.btn_in = 1'b0;
    bus_l.btn_in = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    n_cmp++;
    if ({bus_h.btn_level, bus_h.btn_press, bus_h.btn_release, bus_h.btn_long} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_h: outputs %b, required 0000",
               {bus_h.btn_level, bus_h.btn_press, bus_h.btn_release, bus_h.btn_long});
    end
    n_cmp++;
    if ({bus_l.btn_level, bus_l.btn_press, bus_l.btn_release, bus_l.btn_long} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_l: outputs %b, required 0000",
               {bus_l.btn_level, bus_l.btn_press, bus_l.btn_release, bus_l.btn_long});
    end
    reset_n = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
  endtask

  // Clean 0->1 step, held: press 7 edges after the step (sampled at step index 6).
  task automatic test_clean_press();
    exp_q.delete();
    push(KPress, 6);
`ifdef BTN_LONG_PRESS_EN
    push(KLong, 16);
`endif
    for (int k = 0; k < 20; k++) begin
      bus_h.btn_in = 1'b1;
      @(posedge sysclk);
      #1;
      obs = {bus_h.btn_long, bus_h.btn_release, bus_h.btn_press};
      lvl = bus_h.btn_level;
      n_cmp++;
      if (lvl !== (k >= 6)) begin
        n_err++;
        $display("FAIL clean_press level step %0d: got %b, required %b", k, lvl, k >= 6);
      end
      for (int b = 0; b < 3; b++) begin
        if (obs[b] === 1'b1) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL clean_press %s: strobe at step %0d, required none", kname(b), k);
          end else begin
            ev = exp_q.pop_front();
            if (ev.kind != b || ev.step != k) begin
              n_err++;
              $display("FAIL clean_press %s: strobe at step %0d, required %s at step %0d",
                       kname(b), k, kname(ev.kind), ev.step);
            end
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL clean_press missing: %0d strobes outstanding, required 0", exp_q.size());
    end
  endtask

  // From pressed: 2 cycles low, 2 cycles bounce high, then settle low at step 4.
  task automatic test_bounce_release();
    exp_q.delete();
    push(KRelease, 10);
    for (int k = 0; k < 20; k++) begin
      bus_h.btn_in = (k == 2 || k == 3);
      @(posedge sysclk);
      #1;
      obs = {bus_h.btn_long, bus_h.btn_release, bus_h.btn_press};
      lvl = bus_h.btn_level;
      n_cmp++;
      if (lvl !== (k < 10)) begin
        n_err++;
        $display("FAIL bounce_release level step %0d: got %b, required %b", k, lvl, k < 10);
      end
      for (int b = 0; b < 3; b++) begin
        if (obs[b] === 1'b1) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL bounce_release %s: strobe at step %0d, required none", kname(b), k);
          end else begin
            ev = exp_q.pop_front();
            if (ev.kind != b || ev.step != k) begin
              n_err++;
              $display("FAIL bounce_release %s: strobe at step %0d, required %s at step %0d",
                       kname(b), k, kname(ev.kind), ev.step);
            end
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL bounce_release missing: %0d strobes outstanding, required 0", exp_q.size());
    end
  endtask

  // Toggle every 2 cycles for 40 cycles, then hold low: nothing may come out.
  task automatic test_fast_toggle();
    exp_q.delete();
    for (int k = 0; k < 50; k++) begin
      bus_h.btn_in = (k < 40) && ((k / 2) % 2 == 0);
      @(posedge sysclk);
      #1;
      obs = {bus_h.btn_long, bus_h.btn_release, bus_h.btn_press};
      lvl = bus_h.btn_level;
      n_cmp++;
      if (lvl !== 1'b0) begin
        n_err++;
        $display("FAIL fast_toggle level step %0d: got %b, required 0", k, lvl);
      end
      n_cmp++;
      if (obs !== 3'b000) begin
        n_err++;
        $display("FAIL fast_toggle strobes step %0d: got %b, required 000", k, obs);
      end
    end
  endtask

  // Inverted polarity: pin idles high, pulled low for 15 steps, then released.
  task automatic test_active_low();
    exp_q.delete();
    push(KPress, 6);
`ifdef BTN_LONG_PRESS_EN
    push(KLong, 16);
`endif
    push(KRelease, 21);
    for (int k = 0; k < 26; k++) begin
      bus_l.btn_in = (k >= 15);
      @(posedge sysclk);
      #1;
      obs = {bus_l.btn_long, bus_l.btn_release, bus_l.btn_press};
      lvl = bus_l.btn_level;
      n_cmp++;
      if (lvl !== (k >= 6 && k < 21)) begin
        n_err++;
        $display("FAIL active_low level step %0d: got %b, required %b", k, lvl, k >= 6 && k < 21);
      end
      for (int b = 0; b < 3; b++) begin
        if (obs[b] === 1'b1) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL active_low %s: strobe at step %0d, required none", kname(b), k);
          end else begin
            ev = exp_q.pop_front();
            if (ev.kind != b || ev.step != k) begin
              n_err++;
              $display("FAIL active_low %s: strobe at step %0d, required %s at step %0d",
                       kname(b), k, kname(ev.kind), ev.step);
            end
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL active_low missing: %0d strobes outstanding, required 0", exp_q.size());
    end
  endtask

  // Reset during PRESS_WAIT (count 3) with the button held: full interval restarts after release.
  task automatic test_reset_mid();
    exp_q.delete();
    push(KPress, 14);
`ifdef BTN_LONG_PRESS_EN
    push(KLong, 24);
`endif
    push(KRelease, 26);
    for (int k = 0; k < 32; k++) begin
      bus_h.btn_in = (k < 20);
      @(posedge sysclk);
      #1;
      obs = {bus_h.btn_long, bus_h.btn_release, bus_h.btn_press};
      lvl = bus_h.btn_level;
      n_cmp++;
      if (lvl !== (k >= 14 && k < 26)) begin
        n_err++;
        $display("FAIL reset_mid level step %0d: got %b, required %b", k, lvl, k >= 14 && k < 26);
      end
      for (int b = 0; b < 3; b++) begin
        if (obs[b] === 1'b1) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL reset_mid %s: strobe at step %0d, required none", kname(b), k);
          end else begin
            ev = exp_q.pop_front();
            if (ev.kind != b || ev.step != k) begin
              n_err++;
              $display("FAIL reset_mid %s: strobe at step %0d, required %s at step %0d",
                       kname(b), k, kname(ev.kind), ev.step);
            end
          end
        end
      end
      if (k == 4) reset_n = 1'b0;
      if (k == 7) reset_n = 1'b1;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_mid missing: %0d strobes outstanding, required 0", exp_q.size());
    end
  endtask

  // Press held 30 cycles: btn_long 10 edges after btn_press when built in, never otherwise.
  task automatic test_long_press();
    exp_q.delete();
    push(KPress, 6);
`ifdef BTN_LONG_PRESS_EN
    push(KLong, 16);
`endif
    push(KRelease, 36);
    for (int k = 0; k < 40; k++) begin
      bus_h.btn_in = (k < 30);
      @(posedge sysclk);
      #1;
      obs = {bus_h.btn_long, bus_h.btn_release, bus_h.btn_press};
      lvl = bus_h.btn_level;
      n_cmp++;
      if (lvl !== (k >= 6 && k < 36)) begin
        n_err++;
        $display("FAIL long_press level step %0d: got %b, required %b", k, lvl, k >= 6 && k < 36);
      end
      for (int b = 0; b < 3; b++) begin
        if (obs[b] === 1'b1) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL long_press %s: strobe at step %0d, required none", kname(b), k);
          end else begin
            ev = exp_q.pop_front();
            if (ev.kind != b || ev.step != k) begin
              n_err++;
              $display("FAIL long_press %s: strobe at step %0d, required %s at step %0d",
                       kname(b), k, kname(ev.kind), ev.step);
            end
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL long_press missing: %0d strobes outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    reset_n      = 1'b0;
    bus_h.btn_in = 1'b0;
    bus_l.btn_in = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce_release();
    test_fast_toggle();
    test_active_low();
    test_reset_mid();
    test_long_press();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
